// File: rtl/decode_issue_pkg.sv
// decode_issue_pkg: shared ISA constants, instruction layout and opcode decode
// for the decode/issue stage in front of the 19-bit execute ALU.
package decode_issue_pkg;

    localparam int ISA_XLEN = 19;
    localparam int ISA_NREG = 8;

    // ALU operation encoding seen by execute
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_DIV = 4'd3;
    localparam logic [3:0] OP_INC = 4'd4;
    localparam logic [3:0] OP_DEC = 4'd5;
    localparam logic [3:0] OP_OR  = 4'd6;
    localparam logic [3:0] OP_AND = 4'd7;
    localparam logic [3:0] OP_XOR = 4'd8;
    localparam logic [3:0] OP_NOT = 4'd9;

    // Load-immediate opcode (issued as an ADD of imm9 and zero)
    localparam logic [3:0] OPC_LDI = 4'd10;

    // Upper 13 bits of an instruction; imm9 overlaps rs2 and the low bits
    typedef struct packed {
        logic [3:0] opcode;
        logic [2:0] rd;
        logic [2:0] rs1;
        logic [2:0] rs2;
    } instr_t;

    typedef struct packed {
        logic       legal;
        logic       ldi;
        logic       unary;
        logic [3:0] op_sel;
    } dec_t;

    function automatic dec_t decode_opc(input logic [3:0] opc);
        dec_t d;
        d = '0;
        d.legal = 1'b1;
        case (opc)
            4'd0:    d.op_sel = OP_ADD;
            4'd1:    d.op_sel = OP_SUB;
            4'd2:    d.op_sel = OP_MUL;
            4'd3:    d.op_sel = OP_DIV;
            4'd4:    begin d.op_sel = OP_INC; d.unary = 1'b1; end
            4'd5:    begin d.op_sel = OP_DEC; d.unary = 1'b1; end
            4'd6:    d.op_sel = OP_OR;
            4'd7:    d.op_sel = OP_AND;
            4'd8:    d.op_sel = OP_XOR;
            4'd9:    begin d.op_sel = OP_NOT; d.unary = 1'b1; end
            OPC_LDI: begin d.op_sel = OP_ADD; d.ldi = 1'b1; end
            default: d.legal = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/decode_regfile.sv
// decode_regfile: NREG x XLEN register file, two async read ports and one
// synchronous write port. r0 reads as zero and ignores writes.
module decode_regfile
    import decode_issue_pkg::*;
#(
    parameter int XLEN = ISA_XLEN,
    parameter int NREG = ISA_NREG,
    parameter int AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   raddr_a,
    output logic [XLEN-1:0] rdata_a,
    input  logic [AW-1:0]   raddr_b,
    output logic [XLEN-1:0] rdata_b,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata
);

    logic [XLEN-1:0] mem [NREG];

    // Storage: cleared on reset, r0 never written
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a = (raddr_a == '0) ? '0 : mem[raddr_a];
    assign rdata_b = (raddr_b == '0) ? '0 : mem[raddr_b];

endmodule

// File: rtl/decode_issue.sv
// decode_issue: decodes 19-bit instructions, reads operands with writeback
// bypass, tracks pending destinations in a scoreboard and presents one
// registered issue slot to execute over valid/ready.
// Optional: define DECODE_PERF_EN to add the saturating stall_cnt_o counter.
module decode_issue
    import decode_issue_pkg::*;
#(
    parameter int XLEN = ISA_XLEN,
    parameter int NREG = ISA_NREG
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            instr_valid_i,
    input  logic [XLEN-1:0] instr_i,
    output logic            instr_ready_o,
    output logic            ex_valid_o,
    input  logic            ex_ready_i,
    output logic [3:0]      op_sel_o,
    output logic [XLEN-1:0] opr_a_o,
    output logic [XLEN-1:0] opr_b_o,
    output logic [2:0]      rd_o,
    input  logic            wb_en_i,
    input  logic [2:0]      wb_addr_i,
    input  logic [XLEN-1:0] wb_data_i,
`ifdef DECODE_PERF_EN
    output logic [15:0]     stall_cnt_o,
`endif
    output logic            illegal_o
);

    instr_t          ins;
    dec_t            dec;
    logic [XLEN-1:0] rf_a, rf_b;
    logic [XLEN-1:0] src_a, src_b;
    logic [XLEN-1:0] opr_a_nxt, opr_b_nxt;
    logic [NREG-1:0] wb_mask;
    logic [NREG-1:0] pend_eff;
    logic [NREG-1:0] pend_nxt;
    logic            wb_live;
    logic            hazard;
    logic            slot_free;
    logic            accept;
    logic            issue;

    logic            vld_p1;
    logic [3:0]      op_sel_p1;
    logic [XLEN-1:0] opr_a_p1, opr_b_p1;
    logic [2:0]      rd_p1;
    logic            ill_p1;
    logic [NREG-1:0] pend_p1;

    assign ins = instr_t'(instr_i[XLEN-1 -: 13]);
    assign dec = decode_opc(ins.opcode);

    decode_regfile #(.XLEN(XLEN), .NREG(NREG)) u_rf (
        .clk     (clk),
        .rst_n   (rst_n),
        .raddr_a (ins.rs1),
        .rdata_a (rf_a),
        .raddr_b (ins.rs2),
        .rdata_b (rf_b),
        .we      (wb_en_i),
        .waddr   (wb_addr_i),
        .wdata   (wb_data_i)
    );

    // A writeback this cycle clears its register's pending bit for hazard purposes
    always_comb begin
        wb_live = wb_en_i && (wb_addr_i != 3'd0);
        wb_mask = '0;
        if (wb_live) begin
            wb_mask[wb_addr_i] = 1'b1;
        end
        pend_eff = pend_p1 & ~wb_mask;
    end

    // Hazard detection and handshake; illegal opcodes only need a free slot
    always_comb begin
        hazard = 1'b0;
        if (dec.legal) begin
            if (!dec.ldi && pend_eff[ins.rs1]) hazard = 1'b1;
            if (!dec.ldi && !dec.unary && pend_eff[ins.rs2]) hazard = 1'b1;
            if (pend_eff[ins.rd]) hazard = 1'b1;
        end
        slot_free     = !vld_p1 || ex_ready_i;
        instr_ready_o = slot_free && (!dec.legal || !hazard);
        accept        = instr_valid_i && instr_ready_o;
        issue         = accept && dec.legal;
    end

    // Operand selection with writeback-to-read bypass
    always_comb begin
        src_a = (wb_live && (wb_addr_i == ins.rs1)) ? wb_data_i : rf_a;
        src_b = (wb_live && (wb_addr_i == ins.rs2)) ? wb_data_i : rf_b;
        if (dec.ldi) begin
            opr_a_nxt = {{(XLEN-9){1'b0}}, instr_i[8:0]};
            opr_b_nxt = '0;
        end else begin
            opr_a_nxt = src_a;
            opr_b_nxt = dec.unary ? '0 : src_b;
        end
    end

    // Scoreboard next state: writeback clears, a same-edge issue to rd sets
    always_comb begin
        pend_nxt = pend_p1 & ~wb_mask;
        if (issue) begin
            pend_nxt[ins.rd] = 1'b1;
        end
        pend_nxt[0] = 1'b0;
    end

    // ---- issue slot stage (p1) ----
    // Issue slot: load on issue, drop valid when consumed, payload otherwise held
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1    <= 1'b0;
            op_sel_p1 <= '0;
            opr_a_p1  <= '0;
            opr_b_p1  <= '0;
            rd_p1     <= '0;
            ill_p1    <= 1'b0;
        end else begin
            ill_p1 <= accept && !dec.legal;
            if (issue) begin
                vld_p1    <= 1'b1;
                op_sel_p1 <= dec.op_sel;
                opr_a_p1  <= opr_a_nxt;
                opr_b_p1  <= opr_b_nxt;
                rd_p1     <= ins.rd;
            end else if (ex_ready_i) begin
                vld_p1 <= 1'b0;
            end
        end
    end

    // Scoreboard register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_p1 <= '0;
        end else begin
            pend_p1 <= pend_nxt;
        end
    end

    assign ex_valid_o = vld_p1;
    assign op_sel_o   = op_sel_p1;
    assign opr_a_o    = opr_a_p1;
    assign opr_b_o    = opr_b_p1;
    assign rd_o       = rd_p1;
    assign illegal_o  = ill_p1;

`ifdef DECODE_PERF_EN
    logic [15:0] stall_cnt_p1;

    // Count cycles an offered instruction is refused, saturating at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_p1 <= '0;
        end else if (instr_valid_i && !instr_ready_o && (stall_cnt_p1 != 16'hFFFF)) begin
            stall_cnt_p1 <= stall_cnt_p1 + 16'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_p1;
`endif

endmodule

// File: doc/decode_issue.md
Name: decode_issue

Overview:
- Instruction decode and issue stage that feeds the 19-bit execute ALU.
- Accepts 19-bit instructions over a valid/ready handshake and reads the source operands from an internal 8x19 register file.
- Tracks pending destination registers with a scoreboard and presents op_sel, operands and rd through a registered valid/ready output.
- Writeback from the end of the pipe updates the register file and clears the scoreboard.

Parameters:
- XLEN, 19, data and instruction width; fixed by the ISA, any other value is unsupported.
- NREG, 8, register count; addressed by 3-bit fields.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- instr_valid_i  in  1  instruction offered
- instr_i  in  19  instruction: [18:15] opcode, [14:12] rd, [11:9] rs1, [8:6] rs2, [8:0] imm9 (LDI only)
- instr_ready_o  out  1  instruction accepted this cycle when high with valid
- ex_valid_o  out  1  issue slot holds a valid op
- ex_ready_i  in  1  execute consumes the slot
- op_sel_o  out  4  ALU operation (pkgs OP_* encoding)
- opr_a_o  out  19  operand A
- opr_b_o  out  19  operand B
- rd_o  out  3  destination register
- wb_en_i  in  1  writeback strobe
- wb_addr_i  in  3  writeback register
- wb_data_i  in  19  writeback data
- illegal_o  out  1  one-cycle pulse: illegal opcode dropped

Behaviour:
- Reset (async, rst_n low):
  - ex_valid_o=0; op_sel_o, opr_a_o, opr_b_o, rd_o all 0; illegal_o=0.
  - All registers 0; all scoreboard bits 0.
- Register file rules:
  - r0 always reads 0 and is never pending.
  - Writebacks to r0 are ignored.
- Opcode decode:
  - 0-9 map 1:1 to OP_ADD, SUB, MUL, DIV, INC, DEC, OR, AND, XOR, NOT.
  - 10 is LDI: op_sel=OP_ADD, opr_a = zero-extended imm9, opr_b=0, no sources read.
  - 11-15 are illegal.
- Operands:
  - Binary ops: opr_a=R[rs1], opr_b=R[rs2].
  - Unary ops (INC, DEC, NOT): opr_a=R[rs1], opr_b=0; rs2 is ignored for hazards.
- Hazard = any used source pending (RAW), or rd pending (WAW).
  - A same-cycle writeback to that register clears the hazard.
  - In that case wb_data_i is bypassed into the operand.
- Handshakes:
  - slot_free = !ex_valid_o || ex_ready_i.
  - instr_ready_o = slot_free && !hazard (combinational). Illegal opcodes ignore the hazard term.
  - Accept (valid && ready) of a legal op: on the next edge, ex_valid_o=1, outputs are loaded, and pending[rd] is set (unless rd=0).
  - Slot consumed with no new accept: ex_valid_o drops to 0; the payload holds its last value.
  - Output payload is stable while ex_valid_o && !ex_ready_i.
- Illegal opcode: consumed and not issued; illegal_o pulses for 1 cycle on the next edge; slot and scoreboard unchanged.
- Timing:
  - Latency is 1 cycle from accept to ex_valid_o.
  - Back-to-back issue at 1/cycle while there are no hazards and ex_ready_i=1.
- Simultaneous events:
  - Writeback clears pending[wb_addr] on the same edge.
  - If the same edge also issues to rd==wb_addr, the set wins (pending stays 1).
  - Writeback to a non-pending register simply updates the register file.
- Reset asserted mid-operation drops any in-flight slot and clears the scoreboard; nothing is replayed.

Optional Feature:
- DECODE_PERF_EN defined:
  - Adds output stall_cnt_o[15:0], reset to 0.
  - Increments each cycle that instr_valid_i && !instr_ready_o, and saturates at 16'hFFFF.
- Undefined: port and logic are absent; behaviour is otherwise identical.

Decomposition:
- pkgs:
  - Add opcode constant OPC_LDI=4'd10.
  - Add a packed instr_t struct (opcode, rd, rs1, rs2) and a function mapping opcode to OP_* with a legal flag.
  - Reuse the existing OP_* constants.
- Sub-module decode_regfile:
  - 8x19 storage, two async read ports, one sync write port.
  - r0 hardwired to 0; async active-low reset clears all entries.
  - Write-to-read bypass is done in decode_issue.

Test Plan:
- Reset, then LDI r1,#5 with ex_ready_i=1 -> next cycle ex_valid_o=1, op_sel_o=OP_ADD, opr_a_o=5, opr_b_o=0, rd_o=1; pending[1]=1.
- Issue ADD r2,r1,r1 while r1 is pending -> instr_ready_o=0. Then wb r1=5 -> ready in that cycle, opr_a_o=opr_b_o=5 (bypass).
- Hold ex_ready_i=0 for 3 cycles after issuing XOR r3,r4,r5 -> payload stable, instr_ready_o=0. Release -> slot drains and the next op is accepted the same cycle.
- Opcode 4'hC -> accepted, illegal_o pulses for one cycle, ex_valid_o unchanged, scoreboard unchanged.
- NOT r6,r7 with R7=19'h00F0F and rs2 field=1 (pending) -> no stall; opr_a_o=19'h00F0F, opr_b_o=0.
- Assert rst_n=0 while ex_valid_o=1 and r2 pending -> outputs 0 immediately, pending cleared; with DECODE_PERF_EN defined, stall_cnt_o=0.
